// File: rtl/cache_index.sv
// cache_index: front stage of the pipelined read cache.
// Buffers CPU read requests in a DEPTH-entry skid FIFO, decodes
// tag/index/offset and presents the current lookup to the access stage.
// sram_idx is driven one cycle ahead so the synchronous array outputs line
// up with caac_o. Across a miss the lookup register is frozen. Once stall
// falls, the lookup is replayed for one cycle (mem_read=0) so the refilled
// line is re-read.
//
// Ports:
//   clk, rst       clock; asynchronous active-low reset
//   cpu_read       CPU read request (accepted when cpu_read && cpu_ready)
//   cpu_address    CPU byte address
//   cpu_ready      FIFO not full
//   stall          access stage: miss outstanding
//   mem_resp       access stage: hit returned, current request retires
//   sram_idx       read/write index into the data/tag/valid arrays
//   caac_o         packed {mem_read, mem_address, tag} to the access stage
//
// Optional: define CACHE_IDX_PERF_EN to add saturating 32-bit counters
// perf_hits and perf_misses.
module cache_index #(
  parameter int TAG_W = 24,
  parameter int IDX_W = 3,
  parameter int OFF_W = 5,
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cpu_read,
  input  logic [TAG_W+IDX_W+OFF_W-1:0]     cpu_address,
  output logic                             cpu_ready,
  input  logic                             stall,
  input  logic                             mem_resp,
  output logic [IDX_W-1:0]                 sram_idx,
`ifdef CACHE_IDX_PERF_EN
  output logic [31:0]                      perf_hits,
  output logic [31:0]                      perf_misses,
`endif
  output logic [2*TAG_W+IDX_W+OFF_W:0]     caac_o
);

  localparam int AW = TAG_W + IDX_W + OFF_W;
  localparam int FW = 1 + AW + TAG_W;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {EMPTY, LOOKUP, HOLD, REPLAY} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   fifo [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [FW-1:0]   caac_q;
  logic            empty, push, pop, retire;
  logic [AW-1:0]   head, caac_addr;
  logic [IDX_W-1:0] head_idx, caac_idx;

  assign empty     = (count == '0);
  assign cpu_ready = (count != CW'(DEPTH));   // no bypass when full
  assign push      = cpu_read && cpu_ready;

  assign head      = fifo[rd_ptr];
  assign head_idx  = head[OFF_W +: IDX_W];
  assign caac_addr = caac_q[TAG_W +: AW];
  assign caac_idx  = caac_addr[OFF_W +: IDX_W];

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    retire    = 1'b0;
    sram_idx  = caac_idx;
    unique case (state)
      EMPTY: begin
        sram_idx = head_idx;
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        // mem_resp has priority over stall
        if (mem_resp) begin
          retire   = 1'b1;
          sram_idx = head_idx;
          if (!empty) pop = 1'b1;
          else        state_nxt = EMPTY;
        end else if (stall) begin
          state_nxt = HOLD;
        end
      end
      HOLD:    if (!stall) state_nxt = REPLAY;
      REPLAY:  state_nxt = LOOKUP;
      default: state_nxt = EMPTY;
    endcase
  end

  // Replay cycle hides the request from the access stage while the
  // refilled line is read back out of the arrays.
  always_comb begin
    caac_o = caac_q;
    if (state == REPLAY) caac_o[FW-1] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      caac_q <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (pop)
        caac_q <= {1'b1, head, head[AW-1 -: TAG_W]};
      else if (retire)
        caac_q[FW-1] <= 1'b0;
    end
  end

  // Storage is cleared too so the EMPTY-state index reads 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else if (push) begin
      fifo[wr_ptr] <= cpu_address;
    end
  end

`ifdef CACHE_IDX_PERF_EN
  logic missed;   // current lookup has already taken a miss

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_hits   <= '0;
      perf_misses <= '0;
      missed      <= 1'b0;
    end else begin
      if (retire && !missed && perf_hits != 32'hFFFF_FFFF)
        perf_hits <= perf_hits + 32'd1;
      if (pop) missed <= 1'b0;
      if (state == LOOKUP && !mem_resp && stall) begin
        missed <= 1'b1;
        if (perf_misses != 32'hFFFF_FFFF) perf_misses <= perf_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_index.sv
// tb_cache_index: random requests scored against a queue of accepted
// addresses; a behavioural access-stage model drives hits, misses and
// replays and checks what the DUT presents each cycle.
module tb_cache_index;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_read = 1'b0;
  logic [31:0] cpu_address = '0;
  logic        cpu_ready;
  logic        stall = 1'b0;
  logic        mem_resp = 1'b0;
  logic [2:0]  sram_idx;
  logic [56:0] caac_o;
`ifdef CACHE_IDX_PERF_EN
  logic [31:0] perf_hits, perf_misses;
`endif

  cache_index dut (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_address(cpu_address),
    .cpu_ready(cpu_ready), .stall(stall), .mem_resp(mem_resp),
    .sram_idx(sram_idx),
`ifdef CACHE_IDX_PERF_EN
    .perf_hits(perf_hits), .perf_misses(perf_misses),
`endif
    .caac_o(caac_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32) % 8);
  endfunction
  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / 256;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // access-stage model: 0 normal lookup, 1 miss outstanding,
  // 2 replay expected, 3 first lookup after replay (must hit)
  int   phase = 0;
  int   miss_left = 0;
  bit   mon_en = 0;
  bit   long_miss = 0;
  bit   cur_missed = 0;
  int   hits_m = 0, misses_m = 0;
  int   m_phase, in_fifo, r;
  logic m_rd, m_resp, m_stl;

  always @(negedge clk) begin
    if (mon_en) begin
      m_rd    = caac_o[56];
      m_phase = phase;
      in_fifo = exp_q.size() - ((m_rd || phase == 2) ? 1 : 0);
      check("cpu_ready", cpu_ready, in_fifo < DEPTH);
      if (m_rd) begin
        if (exp_q.size() == 0) check("spurious_read", m_rd, 0);
        else begin
          check("mem_address", caac_o[55:24], exp_q[0]);
          check("tag", caac_o[23:0], tag_of(exp_q[0]));
        end
      end
      m_resp = 0; m_stl = 0;
      case (phase)
        0: begin
          if (m_rd) begin
            r = $urandom_range(0, 9);
            if (long_miss || r >= 7) begin
              m_stl = 1; phase = 1; misses_m++; cur_missed = 1;
              miss_left = long_miss ? 30 : $urandom_range(0, 4);
            end else if (r < 5) begin
              m_resp = 1; m_stl = 1'($urandom_range(0, 1));
            end
          end else begin
            m_resp = 1'($urandom_range(0, 1));
            m_stl  = 1'($urandom_range(0, 1));
          end
        end
        1: begin
          check("hold_read", m_rd, 1);
          m_resp = 1'($urandom_range(0, 1));   // must be ignored
          if (miss_left > 0) begin m_stl = 1; miss_left--; end
          else phase = 2;
        end
        2: begin
          check("replay_read", m_rd, 0);
          m_resp = 1'($urandom_range(0, 1));   // must be ignored
          phase = 3;
        end
        default: begin
          check("post_replay_read", m_rd, 1);
          m_resp = 1; m_stl = 1'($urandom_range(0, 1));
          phase = 0;
        end
      endcase
      stall = m_stl;
      mem_resp = m_resp;
      #1;
      if (m_rd && m_resp && (m_phase == 0 || m_phase == 3)) begin
        if (exp_q.size() > 1) check("sram_idx_next", sram_idx, idx_of(exp_q[1]));
        if (exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          if (!cur_missed) hits_m++;
          cur_missed = 0;
        end
      end else if (exp_q.size() > 0) begin
        check("sram_idx_cur", sram_idx, idx_of(exp_q[0]));
      end
    end
  end

  task automatic step();
    @(negedge clk); #2;
  endtask

  task automatic send(input logic [31:0] a);
    int guard = 0;
    cpu_read = 1; cpu_address = a;
    while (!cpu_ready && guard < 200) begin step(); guard++; end
    if (!cpu_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got cpu_ready=0, expected 1 within 200 cycles");
    end else exp_q.push_back(a);
    step();
    cpu_read = 0;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while ((exp_q.size() != 0 || phase != 0) && guard < 500) begin step(); guard++; end
    check(name, exp_q.size(), 0);
  endtask

  logic [31:0] dir_addr [6] = '{32'h0000_0120, 32'h0, 32'h20, 32'h40, 32'h60, 32'h0000_00E0};

  initial begin
    #3;
    check("reset_caac", caac_o, 0);
    check("reset_ready", cpu_ready, 1);
    check("reset_sram_idx", sram_idx, 0);
    mon_en = 1;
    #5 rst = 1;
    step();
    foreach (dir_addr[i]) send(dir_addr[i]);
    drain("drain_directed");
    for (int n = 0; n < 150; n++) begin
      send(($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_01E0) : $urandom);
      repeat ($urandom_range(0, 2)) step();
    end
    drain("drain_random");
`ifdef CACHE_IDX_PERF_EN
    check("perf_hits", perf_hits, hits_m);
    check("perf_misses", perf_misses, misses_m);
`endif
    // async reset in the middle of a miss
    long_miss = 1;
    send(32'h0000_00E0);
    for (int i = 0; i < 50 && phase != 1; i++) step();
    check("reached_hold", phase, 1);
    repeat (3) step();
    @(posedge clk); #3;
    mon_en = 0; rst = 0;
    #1;
    check("midhold_caac", caac_o, 0);
    check("midhold_ready", cpu_ready, 1);
    check("midhold_sram_idx", sram_idx, 0);
    exp_q.delete();
    phase = 0; miss_left = 0; cur_missed = 0; long_miss = 0;
    stall = 0; mem_resp = 0;
    step();
    rst = 1; mon_en = 1;
    step();
    send(32'h0000_0120);
    drain("drain_after_reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got no completion, expected finish before 500000ns");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
